// File: rtl/draw_pkg.sv
// Shared widths, rectangle record and scheduler state encoding for the draw scheduler.
// Holds no logic; imported by the scheduler and its shadow store.
package draw_pkg;

  localparam int X_W  = 8;
  localparam int Y_W  = 7;
  localparam int SZ_W = 5;
  localparam int C_W  = 3;

  localparam logic [C_W-1:0] BG_COLOUR_DEF = 3'b000;

  typedef struct packed {
    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;
    logic [SZ_W-1:0] w;
    logic [SZ_W-1:0] h;
  } pos_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ERASE_LD,
    ST_ERASE_RUN,
    ST_DRAW_SEL,
    ST_DRAW_LD,
    ST_DRAW_RUN,
    ST_NEXT,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/obj_shadow_regs.sv
// Per-slot copy of the last rectangle drawn plus its valid bit, so the next frame can erase it.
// Write lands on the next clock edge; read is combinational; no backpressure.
module obj_shadow_regs
  import draw_pkg::*;
#(
  parameter int NUM_OBJ = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_we,
  input  logic [$clog2(NUM_OBJ)-1:0] i_waddr,
  input  logic                       i_wvld,
  input  pos_t                       i_wpos,
  input  logic [$clog2(NUM_OBJ)-1:0] i_raddr,
  output logic                       o_rvld,
  output pos_t                       o_rpos
);

  pos_t               r_pos [NUM_OBJ];
  logic [NUM_OBJ-1:0] r_vld;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        r_pos[i] <= '0;
      end
    end else if (i_we) begin
      r_vld[i_waddr] <= i_wvld;
      r_pos[i_waddr] <= i_wpos;
    end
  end

  assign o_rvld = r_vld[i_raddr];
  assign o_rpos = r_pos[i_raddr];

endmodule

// File: rtl/draw_scheduler.sv
// Walks the object table once per start, erasing each slot's previous rectangle then drawing the new one.
// Engine handshake is load strobe then run until drw_done (ignored in first run cycle) or TIMEOUT.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int             NUM_OBJ   = 8,
  parameter logic [C_W-1:0] BG_COLOUR = BG_COLOUR_DEF,
  parameter int             TIMEOUT   = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic [$clog2(NUM_OBJ)-1:0] obj_idx,
  input  logic                       obj_valid,
  input  logic [X_W-1:0]             obj_x,
  input  logic [Y_W-1:0]             obj_y,
  input  logic [SZ_W-1:0]            obj_w,
  input  logic [SZ_W-1:0]            obj_h,
  input  logic [C_W-1:0]             obj_c,
  output logic [X_W-1:0]             drw_x,
  output logic [Y_W-1:0]             drw_y,
  output logic [SZ_W-1:0]            drw_w,
  output logic [SZ_W-1:0]            drw_h,
  output logic [C_W-1:0]             drw_c,
  output logic                       drw_load_n,
  output logic                       drw_en,
  input  logic                       drw_done,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       err
);

  localparam int IDX_W = $clog2(NUM_OBJ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OBJ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  pos_t             r_drw_pos;
  logic [C_W-1:0]   r_drw_c;
  logic             r_load_n;
  logic             r_en;
  logic             r_busy;
  logic             r_frame_done;
  logic             r_err;

  logic             w_shadow_vld;
  pos_t             w_shadow_pos;
  pos_t             w_obj_pos;
  logic             w_shadow_we;
  logic             w_run_done;
  logic             w_run_tmo;

  assign w_obj_pos   = '{x: obj_x, y: obj_y, w: obj_w, h: obj_h};
  assign w_shadow_we = (r_state == ST_DRAW_SEL);
  // The first run cycle's cnt is zero, which masks a done left over from the previous rectangle.
  assign w_run_done  = (r_cnt != '0) && drw_done;
  assign w_run_tmo   = (r_cnt == CNT_LAST);

  obj_shadow_regs #(
    .NUM_OBJ (NUM_OBJ)
  ) u_shadow (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_we    (w_shadow_we),
    .i_waddr (r_idx),
    .i_wvld  (obj_valid),
    .i_wpos  (w_obj_pos),
    .i_raddr (r_idx),
    .o_rvld  (w_shadow_vld),
    .o_rpos  (w_shadow_pos)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_drw_pos    <= '0;
      r_drw_c      <= '0;
      r_load_n     <= 1'b1;
      r_en         <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (w_shadow_vld) begin
            r_drw_pos <= w_shadow_pos;
            r_drw_c   <= BG_COLOUR;
            r_load_n  <= 1'b0;
            r_state   <= ST_ERASE_LD;
          end else begin
            r_state   <= ST_DRAW_SEL;
          end
        end
        ST_ERASE_LD, ST_DRAW_LD: begin
          r_load_n <= 1'b1;
          r_en     <= 1'b1;
          r_cnt    <= '0;
          r_state  <= (r_state == ST_ERASE_LD) ? ST_ERASE_RUN : ST_DRAW_RUN;
        end
        ST_ERASE_RUN, ST_DRAW_RUN: begin
          if (w_run_done || w_run_tmo) begin
            if (!w_run_done) begin
              r_err <= 1'b1;
            end
            r_en    <= 1'b0;
            r_state <= (r_state == ST_ERASE_RUN) ? ST_DRAW_SEL : ST_NEXT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DRAW_SEL: begin
          if (obj_valid) begin
            r_drw_pos <= w_obj_pos;
            r_drw_c   <= obj_c;
            r_load_n  <= 1'b0;
            r_state   <= ST_DRAW_LD;
          end else begin
            r_state   <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (r_idx == IDX_LAST) begin
            r_frame_done <= 1'b1;
            r_state      <= ST_FINISH;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_state <= ST_SELECT;
          end
        end
        ST_FINISH: begin
          r_frame_done <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_load_n     <= 1'b1;
          r_en         <= 1'b0;
          r_busy       <= 1'b0;
          r_frame_done <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign obj_idx    = r_idx;
  assign drw_x      = r_drw_pos.x;
  assign drw_y      = r_drw_pos.y;
  assign drw_w      = r_drw_pos.w;
  assign drw_h      = r_drw_pos.h;
  assign drw_c      = r_drw_c;
  assign drw_load_n = r_load_n;
  assign drw_en     = r_en;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign err        = r_err;

endmodule
